// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and default sizes for the receive-FIFO read controller.
package fifo_rd_ctrl_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } rd_state_t;

endpackage

// File: rtl/fifo_occ_cnt.sv
// Saturating up/down occupancy counter (0..MAX) with synchronous clear.
module fifo_occ_cnt
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int unsigned MAX   = DEPTH_DEF,
   parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   // Simultaneous inc and dec cancel; both directions saturate instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !dec_i && (cnt_q != CNT_W'(MAX))) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a first-word-fall-through receive FIFO.
// Drains in bursts once THRESH words are buffered or after an idle timeout,
// hands words to a valid/ready consumer, and supports a discard-all flush.
// Optional sticky overflow flag: define FIFO_RD_CTRL_OVF_EN.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned THRESH  = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fifo_w_enable,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_r_data,
   output logic              fifo_r_enable,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush_req,
   output logic              busy,
   output logic              ovf_flag
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   rd_state_t         state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [TMR_W-1:0]  timer_d;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              busy_q;
   logic [OCC_W-1:0]  occ;
   logic              wr_accept;
   logic              occ_clr;
   logic              thresh_hit;
   logic              timeout_hit;
   logic              pop;

   assign wr_accept   = fifo_w_enable && !fifo_full;
   assign thresh_hit  = occ >= OCC_W'(THRESH);
   assign timer_d     = timer_q + TMR_W'(1);
   // Compared after the increment so WAIT lasts TIMEOUT-1 cycles before DRAIN.
   assign timeout_hit = timer_d == TMR_W'(TIMEOUT - 1);
   // Resynchronise the count when a flush completes, unless a write lands now.
   assign occ_clr     = (state_q == FLUSH) && fifo_empty && !wr_accept;

   fifo_occ_cnt #(
      .MAX   (DEPTH),
      .CNT_W (OCC_W)
   ) u_occ (
      .clk_i  (clk),
      .rst_ni (n_rst),
      .clr_i  (occ_clr),
      .inc_i  (wr_accept),
      .dec_i  (pop),
      .cnt_o  (occ)
   );

   // Pop strobe: refill the output register in DRAIN, discard everything in FLUSH.
   always_comb begin
      pop = 1'b0;
      case (state_q)
         DRAIN:   pop = !fifo_empty && (!out_valid_q || out_ready);
         FLUSH:   pop = !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   // Main FSM with drain timer and registered output word; flush overrides all.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else if (flush_req && (state_q != FLUSH)) begin
         state_q     <= FLUSH;
         timer_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               timer_q <= '0;
               if (thresh_hit) begin
                  state_q <= DRAIN;
                  busy_q  <= 1'b1;
               end else if (occ != '0) begin
                  state_q <= WAIT;
                  busy_q  <= 1'b1;
               end
            end
            WAIT: begin
               if (thresh_hit || timeout_hit) begin
                  state_q <= DRAIN;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_d;
               end
            end
            DRAIN: begin
               if (pop) begin
                  out_data_q  <= fifo_r_data;
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
               if ((occ == '0) && !out_valid_q && !pop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            FLUSH: begin
               out_valid_q <= 1'b0;
               if (fifo_empty) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_RD_CTRL_OVF_EN
   logic ovf_q;

   // Sticky record of a write attempted against a full FIFO; flush clears it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ovf_q <= 1'b0;
      end else if (flush_req) begin
         ovf_q <= 1'b0;
      end else if (fifo_w_enable && fifo_full) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf_flag = ovf_q;
`else
   assign ovf_flag = 1'b0;
`endif

   assign fifo_r_enable = pop;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: behavioural FWFT FIFO, scoreboard of
// accepted writes, table-driven bursts and hand-written corner sequences.
module tb_fifo_rd_ctrl;
   import fifo_rd_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       fifo_w_enable;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_r_data;
   logic       fifo_r_enable;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       flush_req;
   logic       busy;
   logic       ovf_flag;
   logic [7:0] w_data;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_xfer   = 0;
   int unsigned n_pops   = 0;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];

`ifdef FIFO_RD_CTRL_OVF_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   fifo_rd_ctrl #(
      .DATA_W  (8),
      .DEPTH   (8),
      .THRESH  (4),
      .TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .fifo_w_enable (fifo_w_enable),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_r_data   (fifo_r_data),
      .fifo_r_enable (fifo_r_enable),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .flush_req     (flush_req),
      .busy          (busy),
      .ovf_flag      (ovf_flag)
   );

   always #5 clk = ~clk;

   // 8-deep first-word-fall-through FIFO model
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fq.delete();
         fifo_empty  <= 1'b1;
         fifo_full   <= 1'b0;
         fifo_r_data <= 8'h00;
      end else begin
         if (fifo_r_enable && (fq.size() > 0)) void'(fq.pop_front());
         if (fifo_w_enable && !fifo_full) fq.push_back(w_data);
         fifo_empty  <= (fq.size() == 0);
         fifo_full   <= (fq.size() >= 8);
         fifo_r_data <= (fq.size() > 0) ? fq[0] : 8'h00;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // One clock: observe/score at the falling edge, return 1 time unit after the rising edge
   task automatic tick();
      @(negedge clk);
      if (fifo_r_enable) begin
         n_pops++;
         chk("pop_while_empty", fifo_empty, 1'b0);
      end
      if (out_valid && out_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) chk("sb_extra_word", exp_q.size(), 1);
         else chk("sb_data", out_data, exp_q.pop_front());
      end
      if (flush_req && (dut.state_q != FLUSH)) exp_q.delete();
      if (fifo_w_enable && !fifo_full) exp_q.push_back(w_data);
      @(posedge clk);
      #1;
   endtask

   task automatic write_words(input int unsigned n, input logic [7:0] base);
      for (int unsigned i = 0; i < n; i++) begin
         fifo_w_enable = 1'b1;
         w_data        = base + 8'(i);
         tick();
      end
      fifo_w_enable = 1'b0;
   endtask

   task automatic run_idle(input int unsigned bound);
      int unsigned n;
      n = 0;
      while ((busy || (exp_q.size() != 0)) && (n < bound)) begin
         tick();
         n++;
      end
      chk("run_idle_bound", (n < bound), 1'b1);
   endtask

   typedef struct {
      int unsigned nw;
      logic [7:0]  base;
      int unsigned stall;
      rd_state_t   exp_st;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int unsigned wc;
      logic        any_valid;

      vecs[0] = '{nw: 1, base: 8'h10, stall: 0, exp_st: WAIT};
      vecs[1] = '{nw: 3, base: 8'h20, stall: 0, exp_st: WAIT};
      vecs[2] = '{nw: 4, base: 8'h30, stall: 0, exp_st: DRAIN};
      vecs[3] = '{nw: 6, base: 8'h40, stall: 3, exp_st: DRAIN};
      vecs[4] = '{nw: 8, base: 8'h50, stall: 0, exp_st: DRAIN};
      vecs[5] = '{nw: 2, base: 8'hC0, stall: 2, exp_st: WAIT};

      n_rst         = 1'b0;
      fifo_w_enable = 1'b0;
      w_data        = 8'h00;
      out_ready     = 1'b0;
      flush_req     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Reset state
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_r_enable", fifo_r_enable, 1'b0);
      chk("rst_ovf", ovf_flag, 1'b0);
      chk("rst_occ", dut.occ, 0);
      chk("rst_state", dut.state_q, IDLE);

      // Four words at threshold: DRAIN the cycle after occ reaches 4, back-to-back delivery
      out_ready = 1'b1;
      write_words(4, 8'h01);
      chk("thr_occ4", dut.occ, 4);
      chk("thr_still_wait", dut.state_q, WAIT);
      tick();
      chk("thr_drain", dut.state_q, DRAIN);
      for (int unsigned i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("thr_valid%0d", i), out_valid, 1'b1);
         chk($sformatf("thr_data%0d", i), out_data, 8'(i + 1));
      end
      tick();
      tick();
      chk("thr_idle", dut.state_q, IDLE);
      chk("thr_busy", busy, 1'b0);

      // Table of bursts with optional consumer stall
      foreach (vecs[v]) begin
         n_xfer    = 0;
         out_ready = (vecs[v].stall == 0);
         write_words(vecs[v].nw, vecs[v].base);
         tick();
         chk($sformatf("vec%0d_state", v), dut.state_q, vecs[v].exp_st);
         repeat (vecs[v].stall) tick();
         out_ready = 1'b1;
         run_idle(200);
         chk($sformatf("vec%0d_xfers", v), n_xfer, vecs[v].nw);
         chk($sformatf("vec%0d_occ", v), dut.occ, 0);
         chk($sformatf("vec%0d_idle", v), dut.state_q, IDLE);
      end

      // Idle timeout with a single word
      n_xfer = 0;
      write_words(1, 8'hA5);
      tick();
      chk("to_enter_wait", dut.state_q, WAIT);
      wc = 0;
      while ((dut.state_q == WAIT) && (wc < 40)) begin
         wc++;
         tick();
      end
      chk("to_wait_cycles", wc, 15);
      chk("to_drain", dut.state_q, DRAIN);
      run_idle(50);
      chk("to_xfers", n_xfer, 1);

      // Backpressure: first word held stable, exactly one pop while stalled
      n_xfer    = 0;
      out_ready = 1'b0;
      write_words(3, 8'h61);
      wc = 0;
      while ((dut.state_q != DRAIN) && (wc < 40)) begin
         wc++;
         tick();
      end
      chk("bp_drain", dut.state_q, DRAIN);
      n_pops = 0;
      for (int unsigned i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
         chk($sformatf("bp_hold%0d", i), out_data, 8'h61);
      end
      chk("bp_one_pop", n_pops, 1);
      out_ready = 1'b1;
      run_idle(50);
      chk("bp_xfers", n_xfer, 3);

      // Fill to full, overflow attempt, then flush
      out_ready = 1'b0;
      write_words(9, 8'h81);
      chk("fl_full", fifo_full, 1'b1);
      chk("fl_occ8", dut.occ, 8);
      fifo_w_enable = 1'b1;
      w_data        = 8'hEE;
      tick();
      fifo_w_enable = 1'b0;
      chk("ovf_set", ovf_flag, EXP_OVF);
      chk("ovf_occ_held", dut.occ, 8);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("fl_state", dut.state_q, FLUSH);
      chk("fl_valid_cleared", out_valid, 1'b0);
      n_pops    = 0;
      any_valid = 1'b0;
      wc        = 0;
      while ((dut.state_q == FLUSH) && (wc < 30)) begin
         if (out_valid) any_valid = 1'b1;
         tick();
         wc++;
      end
      chk("fl_pops", n_pops, 8);
      chk("fl_no_valid", any_valid, 1'b0);
      chk("fl_idle", dut.state_q, IDLE);
      chk("fl_occ0", dut.occ, 0);
      chk("fl_ovf_cleared", ovf_flag, 1'b0);
      chk("fl_empty", fifo_empty, 1'b1);

      // Asynchronous reset in the middle of a stalled drain
      out_ready = 1'b0;
      write_words(5, 8'h91);
      tick();
      tick();
      chk("rd_pre_valid", out_valid, 1'b1);
      chk("rd_pre_busy", busy, 1'b1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("rd_valid", out_valid, 1'b0);
      chk("rd_busy", busy, 1'b0);
      chk("rd_occ", dut.occ, 0);
      chk("rd_data", out_data, 8'h00);
      exp_q.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      tick();
      chk("rd_after_idle", dut.state_q, IDLE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the 8-deep receive FIFO (first-word-fall-through: head word visible on r_data whenever not empty).
- Tracks FIFO occupancy and decides when to drain: burst once a threshold is reached, or on an idle timeout.
- Presents popped words to a downstream consumer over a valid/ready handshake.
- Supports a flush that discards all buffered data.

Parameters:
DATA_W, 8, word width
DEPTH, 8, FIFO depth; occupancy counter range 0..DEPTH
THRESH, 4, occupancy at which draining starts (1..DEPTH)
TIMEOUT, 16, cycles in WAIT before forced drain (>=2)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
fifo_w_enable  in  1  writer-side write strobe (monitored only)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_r_data  in  DATA_W  FIFO head word
fifo_r_enable  out  1  pop strobe to FIFO
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer accepts word this cycle
out_data  out  DATA_W  word to consumer
flush_req  in  1  single-cycle request to discard all data
busy  out  1  state != IDLE
ovf_flag  out  1  sticky overflow (optional feature)

Behaviour:
- Reset (async, n_rst=0) forces: state IDLE, occ=0, timer=0, fifo_r_enable=0, out_valid=0, out_data=0, busy=0, ovf_flag=0.
- Reset applied mid-drain discards the output register contents.
- Occupancy counter occ, width $clog2(DEPTH+1):
  - +1 on fifo_w_enable && !fifo_full.
  - -1 on fifo_r_enable.
  - Both in the same cycle: unchanged.
  - Saturates at DEPTH and at 0 (no wrap).
- fifo_r_enable is asserted only when fifo_empty=0; it is never asserted while empty.
- States:
  - IDLE:
    - occ>0 -> WAIT.
    - If occ>=THRESH, go directly to DRAIN.
    - Timer cleared.
  - WAIT:
    - Timer increments every cycle.
    - occ>=THRESH or timer==TIMEOUT-1 -> DRAIN; timer cleared.
  - DRAIN:
    - fifo_r_enable = !fifo_empty && (!out_valid || out_ready), combinational.
    - On a pop, out_data <= fifo_r_data and out_valid <= 1 at the next edge.
    - Exit to IDLE when occ==0, out_valid==0, and no pop is in progress.
  - FLUSH:
    - fifo_r_enable = !fifo_empty every cycle; data is discarded.
    - out_valid forced to 0 on entry.
    - -> IDLE when fifo_empty=1.
- flush_req in any state -> FLUSH at the next edge; it has priority over all other transitions. flush_req while already in FLUSH is ignored.
- Output handshake:
  - Word transfers on out_valid && out_ready.
  - out_valid and out_data are held stable until transfer.
  - Throughput is 1 word/cycle when out_ready is held high.
  - Pop-to-out_valid latency is 1 cycle.
- Writes arriving during DRAIN are drained in the same burst. No return to WAIT until IDLE is reached.

Optional Feature:
- Macro FIFO_RD_CTRL_OVF_EN.
- Defined:
  - ovf_flag is set on fifo_w_enable && fifo_full.
  - It is sticky and cleared only by flush_req or reset.
  - The count is unaffected by a dropped write.
- Undefined: ovf_flag is tied 0 and no overflow logic is synthesized.

Decomposition:
- Package fifo_rd_ctrl_pkg:
  - state enum rd_state_t {IDLE, WAIT, DRAIN, FLUSH}, 2-bit.
  - Default width constants DATA_W_DEF=8 and DEPTH_DEF=8.
- Sub-module fifo_occ_cnt: parameterized saturating up/down occupancy counter with inc, dec, and clear inputs.
- The FSM, timer and output register live in fifo_rd_ctrl.

Test Plan:
- Reset with n_rst=0 mid-DRAIN, out_valid=1 -> out_valid=0, busy=0, occ=0 immediately, asynchronously.
- Write 4 words 0x01..0x04, out_ready=1 -> DRAIN entered the cycle after occ=4; out_data 0x01,0x02,0x03,0x04 on 4 consecutive cycles; then IDLE.
- Write 1 word 0xA5, no further writes -> stays in WAIT for 15 cycles; DRAIN on cycle 16; 0xA5 delivered; IDLE.
- Backpressure: 3 words queued in DRAIN, out_ready=0 for 5 cycles -> out_data=first word held stable, exactly 1 pop; order preserved after out_ready=1.
- Fill to 8 words, flush_req pulse -> FLUSH, 8 pops with out_valid=0 throughout; IDLE when fifo_empty=1; occ=0.
- With FIFO_RD_CTRL_OVF_EN: write a 9th word while fifo_full=1 -> ovf_flag=1 and occ stays 8; flush_req clears it. Without the macro, ovf_flag stays 0.
